// File: rtl/ad_demod_pkg.sv
// ad_demod_pkg -- shared widths, FSM encoding and output conversion for ad_demod.
//   SAMP_W : sample / reference width (two's complement)
//   ADDR_W : buffer address width
//   ACC_W  : accumulator width (2047 full-scale 28-bit products fit without overflow)
//   OUT_W  : IOut/QOut width
// Optional feature: define AD_DEMOD_SAT_EN to saturate the accumulators into the
// 32-bit outputs; otherwise the outputs take the low 32 accumulator bits (wrapping).
package ad_demod_pkg;

  localparam int SAMP_W = 14;
  localparam int ADDR_W = 11;
  localparam int ACC_W  = 39;
  localparam int OUT_W  = 32;
  localparam int PROD_W = 2 * SAMP_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic signed [ACC_W-1:0] OUT_MAX = 39'sd2147483647;
  localparam logic signed [ACC_W-1:0] OUT_MIN = -39'sd2147483648;

  function automatic logic signed [OUT_W-1:0] acc_to_out(input logic signed [ACC_W-1:0] a);
`ifdef AD_DEMOD_SAT_EN
    if (a > OUT_MAX)      return OUT_MAX[OUT_W-1:0];
    else if (a < OUT_MIN) return OUT_MIN[OUT_W-1:0];
    else                  return a[OUT_W-1:0];
`else
    return a[OUT_W-1:0];
`endif
  endfunction

endpackage

// File: rtl/ad_demod_mac.sv
// ad_demod_mac -- registered signed multiply followed by a 39-bit accumulate.
//   i_clk, i_rst : clock, async active-high reset
//   i_clr        : clear the accumulator (wins over i_acc_en)
//   i_prod_en    : operands valid this cycle; product register loads a*b (else 0)
//   i_acc_en     : product register valid; add it, sign-extended, into the accumulator
//   i_a, i_b     : signed operands
//   o_acc        : accumulator
module ad_demod_mac
  import ad_demod_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_prod_en,
  input  logic                     i_acc_en,
  input  logic signed [SAMP_W-1:0] i_a,
  input  logic signed [SAMP_W-1:0] i_b,
  output logic signed [ACC_W-1:0]  o_acc
);

  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] r_prod;
  logic signed [ACC_W-1:0]  r_acc;

  assign w_prod = PROD_W'(i_a) * PROD_W'(i_b);
  assign o_acc  = r_acc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prod <= '0;
      r_acc  <= '0;
    end else begin
      // Zero when idle so stray bus data never reaches the accumulator.
      r_prod <= i_prod_en ? w_prod : '0;
      if (i_clr)
        r_acc <= '0;
      else if (i_acc_en)
        r_acc <= r_acc + {{(ACC_W-PROD_W){r_prod[PROD_W-1]}}, r_prod};
    end
  end

endmodule

// File: rtl/ad_demod.sv
// ad_demod -- reads SampNum stored samples with sine/cosine references and
// accumulates the I/Q products, presenting the sums on IOut/QOut with Done.
//   CLK, RST        : clock, async active-high reset
//   Enable          : level request; high starts/holds a run, low aborts and re-arms
//   RdEn, RdAddr    : buffer read strobe and address
//   RdData, SinRef, CosRef : buffer data, valid one cycle after the address
//   IOut, QOut      : signed results of the last completed run
//   Done            : run complete, held until Enable falls
// Build option: AD_DEMOD_SAT_EN selects saturating output conversion.
module ad_demod
  import ad_demod_pkg::*;
#(
  parameter int SampNum = 500
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Enable,
  output logic                     RdEn,
  output logic [ADDR_W-1:0]        RdAddr,
  input  logic signed [SAMP_W-1:0] RdData,
  input  logic signed [SAMP_W-1:0] SinRef,
  input  logic signed [SAMP_W-1:0] CosRef,
  output logic signed [OUT_W-1:0]  IOut,
  output logic signed [OUT_W-1:0]  QOut,
  output logic                     Done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SampNum - 1);

  state_t r_state, w_next;
  logic [1:0] r_drain_cnt;
  // [0]: bus data valid this cycle, [1]: product registers valid this cycle
  logic [1:0] r_vld_pipe;
  logic       w_start, w_finish;
  logic signed [ACC_W-1:0] w_acc_i, w_acc_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_finish = 1'b0;
    if (!Enable) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_next  = S_READ;
          w_start = 1'b1;
        end
        S_READ:  if (RdAddr == LAST_ADDR) w_next = S_DRAIN;
        S_DRAIN: if (r_drain_cnt == 2'd2) begin
          w_next   = S_HOLD;
          w_finish = 1'b1;
        end
        default: w_next = S_HOLD;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RdEn        <= 1'b0;
      RdAddr      <= '0;
      r_drain_cnt <= '0;
      r_vld_pipe  <= '0;
      Done        <= 1'b0;
      IOut        <= '0;
      QOut        <= '0;
    end else begin
      RdEn <= (w_next == S_READ);
      if (w_start)
        RdAddr <= '0;
      else if (w_next == S_READ)
        RdAddr <= RdAddr + 1'b1;
      r_drain_cnt <= (r_state == S_DRAIN && w_next == S_DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;
      // An abort flushes in-flight data so a restart begins from a clean pipe.
      r_vld_pipe  <= (w_next == S_IDLE) ? 2'b00 : {r_vld_pipe[0], RdEn};
      Done        <= (w_next == S_HOLD);
      if (w_finish) begin
        IOut <= acc_to_out(w_acc_i);
        QOut <= acc_to_out(w_acc_q);
      end
    end
  end

  ad_demod_mac u_mac_i (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_clr     (w_start),
    .i_prod_en (r_vld_pipe[0]),
    .i_acc_en  (r_vld_pipe[1]),
    .i_a       (RdData),
    .i_b       (SinRef),
    .o_acc     (w_acc_i)
  );

  ad_demod_mac u_mac_q (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_clr     (w_start),
    .i_prod_en (r_vld_pipe[0]),
    .i_acc_en  (r_vld_pipe[1]),
    .i_a       (RdData),
    .i_b       (CosRef),
    .o_acc     (w_acc_q)
  );

endmodule

// File: tb/tb_ad_demod.sv
// tb_ad_demod -- three ad_demod instances (SampNum 4, 500, 2047) fed from
// behavioural buffers; expected I/Q sums are computed from the buffer contents
// when a run is launched and queued, then popped when Done rises.
module tb_ad_demod;

  logic CLK = 1'b0;
  logic RST;
  logic [2:0]        en;
  logic [2:0]        rden, dn;
  logic [2:0][10:0]  addr;
  logic [2:0][13:0]  rd, sn, cs;
  logic [2:0][31:0]  io, qo;

  logic signed [13:0] md [3][2048];
  logic signed [13:0] ms [3][2048];
  logic signed [13:0] mc [3][2048];

  int tests = 0;
  int fails = 0;
  logic signed [31:0] qi[$], qq[$];
  logic signed [31:0] last_i[3], last_q[3];

  always #5 CLK = ~CLK;

  ad_demod #(.SampNum(4)) u0 (
    .CLK(CLK), .RST(RST), .Enable(en[0]), .RdEn(rden[0]), .RdAddr(addr[0]),
    .RdData(rd[0]), .SinRef(sn[0]), .CosRef(cs[0]), .IOut(io[0]), .QOut(qo[0]), .Done(dn[0]));
  ad_demod #(.SampNum(500)) u1 (
    .CLK(CLK), .RST(RST), .Enable(en[1]), .RdEn(rden[1]), .RdAddr(addr[1]),
    .RdData(rd[1]), .SinRef(sn[1]), .CosRef(cs[1]), .IOut(io[1]), .QOut(qo[1]), .Done(dn[1]));
  ad_demod #(.SampNum(2047)) u2 (
    .CLK(CLK), .RST(RST), .Enable(en[2]), .RdEn(rden[2]), .RdAddr(addr[2]),
    .RdData(rd[2]), .SinRef(sn[2]), .CosRef(cs[2]), .IOut(io[2]), .QOut(qo[2]), .Done(dn[2]));

  // Synchronous-read buffers: data for an address appears one cycle later.
  always @(posedge CLK) begin
    rd[0] <= md[0][addr[0]]; sn[0] <= ms[0][addr[0]]; cs[0] <= mc[0][addr[0]];
    rd[1] <= md[1][addr[1]]; sn[1] <= ms[1][addr[1]]; cs[1] <= mc[1][addr[1]];
    rd[2] <= md[2][addr[2]]; sn[2] <= ms[2][addr[2]]; cs[2] <= mc[2][addr[2]];
  end

  function automatic logic signed [31:0] model_out(input logic signed [63:0] s);
`ifdef AD_DEMOD_SAT_EN
    if (s > 64'sd2147483647)  return 32'h7fffffff;
    if (s < -64'sd2147483648) return 32'h80000000;
`endif
    return s[31:0];
  endfunction

  function automatic logic signed [63:0] dot(input int u, input int n, input bit use_cos);
    logic signed [63:0] s = 0;
    for (int k = 0; k < n; k++)
      s += 64'(md[u][k]) * 64'(use_cos ? mc[u][k] : ms[u][k]);
    return s;
  endfunction

  task automatic fill_rand(input int u);
    for (int k = 0; k < 2048; k++) begin
      md[u][k] = 14'($urandom); ms[u][k] = 14'($urandom); mc[u][k] = 14'($urandom);
    end
  endtask

  // Launch (or continue, if Enable is already high) a run and check it end to end.
  task automatic run_check(input int u, input int n, input string tag, input bit pre);
    int done_e = -1;
    logic signed [31:0] ei, eq;
    qi.push_back(model_out(dot(u, n, 1'b0)));
    qq.push_back(model_out(dot(u, n, 1'b1)));
    if (!pre) begin @(negedge CLK); en[u] = 1'b1; end
    for (int e = 0; e <= n + 8 && done_e < 0; e++) begin
      @(posedge CLK); #1;
      if (e == 0 || e == n - 1) begin
        tests++;
        if (rden[u] !== 1'b1 || addr[u] !== 11'(e)) begin
          fails++;
          $display("FAIL %s read E%0d: RdEn=%b RdAddr=%0d, want 1/%0d", tag, e, rden[u], addr[u], e);
        end
      end
      if (e == n) begin
        tests++;
        if (rden[u] !== 1'b0 || addr[u] !== 11'(n - 1)) begin
          fails++;
          $display("FAIL %s read end E%0d: RdEn=%b RdAddr=%0d, want 0/%0d", tag, e, rden[u], addr[u], n - 1);
        end
      end
      if (dn[u] === 1'b1) done_e = e;
    end
    tests++;
    if (done_e != n + 3) begin
      fails++;
      $display("FAIL %s done edge: got E%0d, want E%0d", tag, done_e, n + 3);
    end
    ei = qi.pop_front();
    eq = qq.pop_front();
    tests++;
    if (io[u] !== ei) begin
      fails++; $display("FAIL %s IOut: got %0d, want %0d", tag, $signed(io[u]), ei);
    end
    tests++;
    if (qo[u] !== eq) begin
      fails++; $display("FAIL %s QOut: got %0d, want %0d", tag, $signed(qo[u]), eq);
    end
    last_i[u] = ei;
    last_q[u] = eq;
  endtask

  task automatic rearm(input int u, input string tag);
    @(negedge CLK); en[u] = 1'b0;
    @(posedge CLK); #1;
    tests++;
    if (dn[u] !== 1'b0 || rden[u] !== 1'b0 || io[u] !== last_i[u] || qo[u] !== last_q[u]) begin
      fails++;
      $display("FAIL %s rearm: Done=%b RdEn=%b I=%0d Q=%0d, want 0/0/%0d/%0d",
               tag, dn[u], rden[u], $signed(io[u]), $signed(qo[u]), last_i[u], last_q[u]);
    end
  endtask

  task automatic test_reset();
    en[0] = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    for (int u = 0; u < 3; u++) begin
      tests++;
      if (rden[u] !== 1'b0 || addr[u] !== 11'd0 || dn[u] !== 1'b0 || io[u] !== 32'd0 || qo[u] !== 32'd0) begin
        fails++;
        $display("FAIL reset u%0d: RdEn=%b addr=%0d Done=%b I=%0d Q=%0d, want all 0",
                 u, rden[u], addr[u], dn[u], io[u], qo[u]);
      end
      last_i[u] = 0; last_q[u] = 0;
    end
    en[0] = 1'b0;
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic test_dc_sin();
    for (int k = 0; k < 4; k++) begin md[0][k] = 14'sd100; ms[0][k] = 14'sd8191; mc[0][k] = 14'sd0; end
    run_check(0, 4, "dc_sin", 1'b0);
  endtask

  // Bus data changes while holding must not disturb the result or restart a run.
  task automatic test_hold();
    bit bad_done = 0, bad_rd = 0;
    fill_rand(0);
    for (int c = 0; c < 12; c++) begin
      @(posedge CLK); #1;
      if (dn[0] !== 1'b1) bad_done = 1;
      if (rden[0] !== 1'b0) bad_rd = 1;
    end
    tests++;
    if (bad_done || bad_rd) begin
      fails++; $display("FAIL hold: Done dropped=%0d RdEn rose=%0d, want 0/0", bad_done, bad_rd);
    end
    tests++;
    if (io[0] !== last_i[0] || qo[0] !== last_q[0]) begin
      fails++;
      $display("FAIL hold result: I=%0d Q=%0d, want %0d/%0d", $signed(io[0]), $signed(qo[0]), last_i[0], last_q[0]);
    end
    rearm(0, "hold");
  endtask

  task automatic test_alt_cos();
    for (int k = 0; k < 4; k++) begin
      md[0][k] = (k % 2 == 0) ? 14'sd1000 : -14'sd1000;
      mc[0][k] = (k % 2 == 0) ? 14'sd2000 : -14'sd2000;
      ms[0][k] = 14'sd0;
    end
    run_check(0, 4, "alt_cos", 1'b0);
    rearm(0, "alt_cos");
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      fill_rand(0);
      run_check(0, 4, "random", 1'b0);
      rearm(0, "random");
    end
  endtask

  task automatic test_full_scale();
    for (int k = 0; k < 2048; k++) begin md[2][k] = -14'sd8192; ms[2][k] = -14'sd8192; mc[2][k] = 14'sd8191; end
    run_check(2, 2047, "full_scale", 1'b0);
    rearm(2, "full_scale");
  endtask

  task automatic test_abort();
    fill_rand(1);
    run_check(1, 500, "pre_abort", 1'b0);
    rearm(1, "pre_abort");
    fill_rand(1);
    @(negedge CLK); en[1] = 1'b1;
    for (int e = 0; e <= 100; e++) @(posedge CLK);
    #1 en[1] = 1'b0;
    @(posedge CLK); #1;
    tests++;
    if (dn[1] !== 1'b0 || rden[1] !== 1'b0) begin
      fails++; $display("FAIL abort E101: Done=%b RdEn=%b, want 0/0", dn[1], rden[1]);
    end
    repeat (6) @(posedge CLK);
    #1;
    tests++;
    if (io[1] !== last_i[1] || qo[1] !== last_q[1]) begin
      fails++;
      $display("FAIL abort keep: I=%0d Q=%0d, want %0d/%0d", $signed(io[1]), $signed(qo[1]), last_i[1], last_q[1]);
    end
    fill_rand(1);
    run_check(1, 500, "restart", 1'b0);
    rearm(1, "restart");
  endtask

  task automatic test_reset_midrun();
    fill_rand(1);
    @(negedge CLK); en[1] = 1'b1;
    repeat (50) @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    tests++;
    if (rden[1] !== 1'b0 || addr[1] !== 11'd0 || dn[1] !== 1'b0 || io[1] !== 32'd0 || qo[1] !== 32'd0) begin
      fails++;
      $display("FAIL async reset: RdEn=%b addr=%0d Done=%b I=%0d Q=%0d, want all 0",
               rden[1], addr[1], dn[1], $signed(io[1]), $signed(qo[1]));
    end
    for (int u = 0; u < 3; u++) begin last_i[u] = 0; last_q[u] = 0; end
    @(negedge CLK); RST = 1'b0;
    run_check(1, 500, "post_reset", 1'b1);
    rearm(1, "post_reset");
  endtask

  initial begin
    for (int u = 0; u < 3; u++)
      for (int k = 0; k < 2048; k++) begin md[u][k] = '0; ms[u][k] = '0; mc[u][k] = '0; end
    en = '0;
    RST = 1'b1;
    test_reset();
    test_dc_sin();
    test_hold();
    test_alt_cos();
    test_random();
    test_full_scale();
    test_abort();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
